// File: rtl/trigger_capture_ctrl.sv
// Triggered acquisition sequencer between the ADC sample path and the capture RAM.
// Waits for a level crossing (or auto timeout / free-run start), then writes DEPTH samples.
module trigger_capture_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 160,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic              stopped,
    output logic [1:0]        state
);

    localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_FREE   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE_ST = 2'b11
    } state_t;

    state_t            cur_state;
    logic [DATA_W-1:0] level_q;
    logic              slope_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid;
    logic [TO_W-1:0]   timeout_cnt;

    logic              trig_hit;
    logic              timed_out;
    logic              start_capture;
    logic [ADDR_W-1:0] next_addr;

    // Crossing needs a valid previous sample, so the first sample after arming never triggers.
    assign trig_hit = prev_valid &&
                      (slope_q ? (prev_q > level_q && sample_data <= level_q)
                               : (prev_q < level_q && sample_data >= level_q));
    assign timed_out     = (mode_q == MODE_AUTO) && (timeout_cnt == TO_LAST);
    assign start_capture = (mode_q == MODE_FREE) || trig_hit || timed_out;
    assign next_addr     = wr_addr + ADDR_W'(1);
    assign state         = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            triggered   <= 1'b0;
            stopped     <= 1'b0;
            level_q     <= '0;
            slope_q     <= 1'b0;
            mode_q      <= MODE_AUTO;
            prev_q      <= '0;
            prev_valid  <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            // Setting on single-shot completion wins over the live-mode clear in the same cycle.
            if (cur_state == DONE_ST && mode_q == MODE_SINGLE)
                stopped <= 1'b1;
            else if (trig_mode != MODE_SINGLE)
                stopped <= 1'b0;

            case (cur_state)
                IDLE: begin
                    if (arm && !stopped) begin
                        cur_state   <= ARMED;
                        busy        <= 1'b1;
                        level_q     <= trig_level;
                        slope_q     <= trig_slope;
                        mode_q      <= trig_mode;
                        prev_valid  <= 1'b0;
                        timeout_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (sample_en) begin
                        prev_q     <= sample_data;
                        prev_valid <= 1'b1;
                        if (start_capture) begin
                            triggered <= trig_hit && (mode_q != MODE_FREE);
                            wr_en     <= 1'b1;
                            wr_addr   <= '0;
                            wr_data   <= sample_data;
                            if (DEPTH == 1) begin
                                cur_state <= DONE_ST;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                cur_state <= CAPTURE;
                            end
                        end else if (mode_q == MODE_AUTO) begin
                            timeout_cnt <= timeout_cnt + TO_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_en) begin
                        wr_en   <= 1'b1;
                        wr_addr <= next_addr;
                        wr_data <= sample_data;
                        if (next_addr == LAST_ADDR) begin
                            cur_state <= DONE_ST;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE_ST: begin
                    cur_state <= IDLE;
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed bench for trigger_capture_ctrl: expected RAM writes are queued as samples are
// driven and checked by a monitor whenever wr_en is seen.
module tb_trigger_capture_ctrl;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 8;
    localparam int DEPTH        = 160;
    localparam int AUTO_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_en;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic [1:0]        trig_mode;
    logic              arm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              triggered;
    logic              stopped;
    logic [1:0]        state;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    trigger_capture_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sample_data(sample_data),
        .trig_level(trig_level), .trig_slope(trig_slope), .trig_mode(trig_mode), .arm(arm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .triggered(triggered), .stopped(stopped), .state(state)
    );

    always #5 clk = ~clk;

    // Every write must match the oldest queued expectation; done only with the last address.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            compared++;
            assert (exp_q.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_write observed addr=%0d data=%0d expected no write", wr_addr, wr_data);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                compared++;
                assert (wr_addr === e.addr) else begin
                    mismatched++;
                    $error("FAIL wr_addr observed=%0d expected=%0d", wr_addr, e.addr);
                end
                compared++;
                assert (wr_data === e.data) else begin
                    mismatched++;
                    $error("FAIL wr_data observed=%0d expected=%0d (addr %0d)", wr_data, e.data, e.addr);
                end
                compared++;
                assert (done === (e.addr == ADDR_W'(DEPTH - 1))) else begin
                    mismatched++;
                    $error("FAIL done_with_write observed=%0b at addr=%0d", done, e.addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one sample strobe; optionally queue the write it should produce.
    task automatic apply_stimulus(input logic [DATA_W-1:0] d, input bit expect_write, input int exp_addr);
        wr_t e;
        if (expect_write) begin
            e.addr = ADDR_W'(exp_addr);
            e.data = d;
            exp_q.push_back(e);
        end
        sample_en   = 1'b1;
        sample_data = d;
        tick();
        sample_en   = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic finish_capture(input int from_addr);
        for (int a = from_addr; a < DEPTH; a++)
            apply_stimulus(DATA_W'(a), 1'b1, a);
        check_output("state_done", 32'(state), 32'd3);
        tick();
        check_output("state_idle_after", 32'(state), 32'd0);
        check_output("busy_idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; sample_data = '0; trig_level = '0;
        trig_slope = 1'b0; trig_mode = 2'b11; arm = 1'b0;
        #12;
        check_output("rst_state", 32'(state), 32'd0);
        check_output("rst_wr_en", 32'(wr_en), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_stopped", 32'(stopped), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        $display("[TB] free-run capture");
        trig_mode = 2'b11;
        arm_pulse();
        check_output("fr_state_armed", 32'(state), 32'd1);
        check_output("fr_busy", 32'(busy), 32'd1);
        finish_capture(0);
        check_output("fr_triggered", 32'(triggered), 32'd0);

        $display("[TB] normal rising level 100");
        trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'd100;
        arm_pulse();
        trig_level = 8'd0;
        trig_slope = 1'b1;
        apply_stimulus(8'd90, 1'b0, 0);
        apply_stimulus(8'd95, 1'b0, 0);
        apply_stimulus(8'd99, 1'b0, 0);
        check_output("nr_still_armed", 32'(state), 32'd1);
        apply_stimulus(8'd100, 1'b1, 0);
        check_output("nr_state_capture", 32'(state), 32'd2);
        check_output("nr_triggered", 32'(triggered), 32'd1);
        apply_stimulus(8'd101, 1'b1, 1);
        finish_capture(2);

        $display("[TB] normal falling level 50");
        trig_slope = 1'b1; trig_level = 8'd50;
        arm_pulse();
        apply_stimulus(8'd60, 1'b0, 0);
        apply_stimulus(8'd50, 1'b1, 0);
        check_output("nf_triggered", 32'(triggered), 32'd1);
        finish_capture(1);
        arm_pulse();
        for (int v = 40; v <= 60; v += 5)
            apply_stimulus(DATA_W'(v), 1'b0, 0);
        check_output("nf_ramp_busy", 32'(busy), 32'd1);
        check_output("nf_ramp_state", 32'(state), 32'd1);
        apply_stimulus(8'd50, 1'b1, 0);
        finish_capture(1);

        $display("[TB] auto timeout");
        trig_mode = 2'b00; trig_slope = 1'b0; trig_level = 8'd200;
        arm_pulse();
        for (int i = 0; i < AUTO_TIMEOUT - 1; i++)
            apply_stimulus(8'd10, 1'b0, 0);
        check_output("auto_before_timeout", 32'(state), 32'd1);
        apply_stimulus(8'd10, 1'b1, 0);
        check_output("auto_timeout_triggered", 32'(triggered), 32'd0);
        finish_capture(1);
        arm_pulse();
        for (int i = 0; i < AUTO_TIMEOUT - 1; i++)
            apply_stimulus(8'd10, 1'b0, 0);
        apply_stimulus(8'd210, 1'b1, 0);
        check_output("auto_cross_triggered", 32'(triggered), 32'd1);
        finish_capture(1);

        $display("[TB] single shot");
        trig_mode = 2'b10; trig_level = 8'd100; trig_slope = 1'b0;
        arm_pulse();
        apply_stimulus(8'd90, 1'b0, 0);
        apply_stimulus(8'd110, 1'b1, 0);
        finish_capture(1);
        check_output("single_stopped", 32'(stopped), 32'd1);
        arm_pulse();
        tick();
        check_output("single_arm_ignored", 32'(state), 32'd0);
        trig_mode = 2'b00;
        tick();
        check_output("single_stopped_clear", 32'(stopped), 32'd0);
        arm_pulse();
        check_output("single_rearm", 32'(state), 32'd1);
        apply_stimulus(8'd90, 1'b0, 0);
        apply_stimulus(8'd110, 1'b1, 0);
        finish_capture(1);

        $display("[TB] reset mid-capture");
        trig_mode = 2'b11;
        arm_pulse();
        for (int a = 0; a <= 40; a++)
            apply_stimulus(DATA_W'(a), 1'b1, a);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check_output("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check_output("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        check_output("mid_rst_triggered", 32'(triggered), 32'd0);
        check_output("mid_rst_state", 32'(state), 32'd0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        arm_pulse();
        arm_pulse();
        check_output("arm_busy_armed", 32'(state), 32'd1);
        for (int a = 0; a < 10; a++)
            apply_stimulus(DATA_W'(a), 1'b1, a);
        arm_pulse();
        check_output("arm_busy_capture", 32'(state), 32'd2);
        finish_capture(10);

        tick();
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trigger_capture_ctrl.md
Name: trigger_capture_ctrl

Overview:
Acquisition sequencer that sits between the ADC sample path and the capture RAM write port. It replaces the untriggered fill step with a triggered capture. The display sequencer pulses arm, and this block waits for a trigger crossing on the incoming samples, writes DEPTH consecutive samples into the RAM, then pulses done. It supports auto, normal, single-shot and free-run trigger modes.

Parameters:
DATA_W, 8, sample and trigger level width
ADDR_W, 8, RAM write address width
DEPTH, 160, samples per capture (one per screen column); DEPTH <= 2**ADDR_W
AUTO_TIMEOUT, 4096, accepted samples in ARMED with no trigger before auto mode forces a capture

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sample_en  in  1  one-cycle strobe per ADC sample (divided sample clock, synchronous to clk)
sample_data  in  DATA_W  current sample, valid when sample_en=1
trig_level  in  DATA_W  trigger threshold, unsigned
trig_slope  in  1  0 = rising, 1 = falling
trig_mode  in  2  00 auto, 01 normal, 10 single, 11 free-run
arm  in  1  one-cycle capture request from the display sequencer
wr_en  out  1  RAM write enable
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  RAM write data
busy  out  1  high in ARMED and CAPTURE
done  out  1  one-cycle pulse: capture complete
triggered  out  1  1 = last capture started on a real trigger; 0 = auto or free-run start
stopped  out  1  single mode has completed one capture; further arm pulses are ignored
state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE

Behaviour:
- Reset (async assert): state=IDLE. wr_en, wr_addr, wr_data, busy, done, triggered and stopped are all 0. prev_valid and timeout counter are cleared. Reset mid-capture abandons the capture; no further writes occur.
- All outputs are registered.
- IDLE:
  - arm=1 and stopped=0 -> ARMED on the next edge.
  - At that edge, latch trig_level, trig_slope and trig_mode into internal registers. Changes to these inputs after arming have no effect until the next arm.
  - Clear prev_valid and the timeout counter.
  - arm while stopped=1 is ignored.
- ARMED, on each sample_en:
  - Trigger condition (unsigned compare, only when prev_valid=1):
    - rising: prev < level && cur >= level
    - falling: prev > level && cur <= level
  - Then prev <= cur and prev_valid <= 1. The first sample after arming can never trigger.
  - Free-run: the first accepted sample starts capture, triggered <= 0.
  - Trigger condition true: start capture, triggered <= 1.
  - Auto mode and timeout counter reaches AUTO_TIMEOUT-1 with no trigger: start capture on this sample, triggered <= 0. A true trigger on the same sample takes priority (triggered=1).
  - Normal and single modes wait indefinitely.
  - Starting sample: the qualifying sample itself is written. Next edge: wr_en=1, wr_addr=0, wr_data=cur; state -> CAPTURE (or DONE if DEPTH=1).
- CAPTURE, on each sample_en:
  - wr_en=1 for one cycle, wr_addr = previous+1, wr_data=sample.
  - The sample producing wr_addr=DEPTH-1 moves state to DONE on the same edge.
  - wr_en is 0 in every cycle without a preceding sample_en.
- DONE: lasts exactly one cycle.
  - done=1, coincident with the final wr_en at addr DEPTH-1.
  - Latched mode single -> stopped <= 1.
  - Next state is IDLE.
  - sample_en in DONE is ignored.
- stopped clears on the cycle after trig_mode input != 10.
- arm while busy or in DONE is ignored; it is not queued.
- Boundaries:
  - level=0 rising never triggers; level=max falling never triggers (auto mode still times out).
  - wr_addr never exceeds DEPTH-1.
  - Exactly DEPTH writes occur per capture.
  - Back-to-back sample_en on consecutive cycles are all accepted.

Test Plan:
- Free-run, DEPTH=160: arm, then 160 sample_en strobes with data=address -> 160 writes, addr 0..159, data 0..159; done high with the addr-159 write; triggered=0; state back to 00.
- Normal rising, level=100: samples 90,95,99,100,101 -> first write addr 0 data 100; triggered=1. Samples before the crossing produce no writes.
- Normal falling, level=50: samples 60,50 -> capture starts at 50. Rising ramp 40->60 in falling mode -> no capture, busy stays 1.
- Auto, AUTO_TIMEOUT=8 override, flat data=10 with level=200 -> capture starts on the 8th sample; triggered=0. Separately, a crossing on the 8th sample -> triggered=1.
- Single: arm, capture completes -> stopped=1; a second arm is ignored (state stays 00). Set trig_mode=00, then arm -> capture proceeds.
- Reset mid-capture at addr 40 -> all outputs 0 immediately. After reset release, arm produces a fresh capture from addr 0; arm pulses during busy are ignored.
